// File: rtl/board_id_pkg.sv
// Shared constants, state encoding and byte selection for the board-ID response frame.
package board_id_pkg;

  localparam int unsigned ID_WIDTH     = 32;
  localparam int unsigned IDX_W        = 3;
  localparam int unsigned WAIT_W       = 16;
  localparam int unsigned ID_FRAME_LEN = 6;
  localparam int unsigned ID_ERR_LEN   = 2;

  localparam logic [7:0] ID_HDR_OK   = 8'h5A;
  localparam logic [7:0] ID_HDR_ERR  = 8'hA5;
  localparam logic [7:0] ID_ERR_CODE = 8'hFF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ID  = 2'd1,
    SEND_OK  = 2'd2,
    SEND_ERR = 2'd3
  } state_t;

  // Byte idx of a good frame: header, ID MSB first, then XOR checksum.
  function automatic logic [7:0] ok_byte(input logic [ID_WIDTH-1:0] id,
                                         input logic [IDX_W-1:0]    idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = ID_HDR_OK;
      3'd1:    b = id[31:24];
      3'd2:    b = id[23:16];
      3'd3:    b = id[15:8];
      3'd4:    b = id[7:0];
      3'd5:    b = id[31:24] ^ id[23:16] ^ id[15:8] ^ id[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/board_id_responder.sv
// Answers a request with a framed copy of the board ID, waiting (bounded) for the ID to become valid.
module board_id_responder
  import board_id_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16384
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                id_ready,
  input  logic [ID_WIDTH-1:0] board_identifier,
  input  logic                req,
  output logic                busy,
  output logic [7:0]          out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                timeout_err
);

  // timeout_err is registered, so it is raised one edge before the wait counter
  // would reach TIMEOUT_CYCLES-1; a one-cycle timeout fires straight from IDLE.
  localparam logic              TIMEOUT_IMMEDIATE = (TIMEOUT_CYCLES == 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    (TIMEOUT_CYCLES > 1) ? WAIT_W'(TIMEOUT_CYCLES - 2) : '0;
  localparam logic [IDX_W-1:0]  OK_LAST  = IDX_W'(ID_FRAME_LEN - 1);
  localparam logic [IDX_W-1:0]  ERR_LAST = IDX_W'(ID_ERR_LEN - 1);

  state_t              state;
  logic [ID_WIDTH-1:0] id_q;
  logic [IDX_W-1:0]    byte_idx;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                accept;

  assign accept = out_valid & out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      id_q        <= '0;
      byte_idx    <= '0;
      wait_cnt    <= '0;
      busy        <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= 8'h00;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            busy <= 1'b1;
            if (id_ready) begin
              id_q      <= board_identifier;
              byte_idx  <= '0;
              out_valid <= 1'b1;
              out_data  <= ID_HDR_OK;
              state     <= SEND_OK;
            end else if (TIMEOUT_IMMEDIATE) begin
              timeout_err <= 1'b1;
              state       <= SEND_ERR;
            end else begin
              wait_cnt <= '0;
              state    <= WAIT_ID;
            end
          end
        end

        WAIT_ID: begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
          if (id_ready) begin
            id_q      <= board_identifier;
            byte_idx  <= '0;
            out_valid <= 1'b1;
            out_data  <= ID_HDR_OK;
            state     <= SEND_OK;
          end else if (wait_cnt == WAIT_LAST) begin
            timeout_err <= 1'b1;
            state       <= SEND_ERR;
          end
        end

        SEND_OK: begin
          if (accept) begin
            if (byte_idx == OK_LAST) begin
              out_valid <= 1'b0;
              busy      <= 1'b0;
              byte_idx  <= '0;
              state     <= IDLE;
            end else begin
              byte_idx <= byte_idx + IDX_W'(1);
              out_data <= ok_byte(id_q, byte_idx + IDX_W'(1));
            end
          end
        end

        SEND_ERR: begin
          // First cycle here carries the timeout pulse; the header follows it.
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= ID_HDR_ERR;
            byte_idx  <= '0;
          end else if (accept) begin
            if (byte_idx == ERR_LAST) begin
              out_valid <= 1'b0;
              busy      <= 1'b0;
              byte_idx  <= '0;
              state     <= IDLE;
            end else begin
              byte_idx <= byte_idx + IDX_W'(1);
              out_data <= ID_ERR_CODE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/board_id_responder.md
# board_id_responder

Downstream consumer of the board-ID generator's `ready` / `board_identifier` outputs. On a single-cycle request from the command layer it waits for a valid ID (bounded by a timeout) and streams it as a framed byte sequence over a valid/ready byte interface. The byte interface feeds the response-packet path. It decouples the slow (~4k-cycle) DNA read from command handling so requests never see a stale or zero ID.

## Interface

**Parameters**
- `TIMEOUT_CYCLES`, default 16384: maximum cycles spent waiting for `id_ready` before an error frame is sent. Legal range 1..65535.

**Ports**
- `clock`, in, 1: single system clock.
- `reset`, in, 1: synchronous, active-high.
- `id_ready`, in, 1: ID-valid flag from the board-ID generator.
- `board_identifier`, in, 32: ID value; meaningful only while `id_ready`=1.
- `req`, in, 1: one-cycle request pulse.
- `busy`, out, 1: high from the cycle after an accepted `req` until the last byte is accepted.
- `out_data`, out, 8: stream byte.
- `out_valid`, out, 1: `out_data` is valid.
- `out_ready`, in, 1: the sink accepts the byte this cycle when both `out_valid` and `out_ready` are 1.
- `timeout_err`, out, 1: one-cycle pulse when a wait times out.

## Operation

**State machine**
- `IDLE`
  - `req`=1 and `id_ready`=1: latch the ID and go to `SEND_OK`.
  - `req`=1 and `id_ready`=0: clear the wait counter and go to `WAIT_ID`.
- `WAIT_ID`
  - Wait counter increments each cycle.
  - `id_ready`=1: latch the ID and go to `SEND_OK`.
  - Otherwise, when the counter reaches `TIMEOUT_CYCLES`-1: pulse `timeout_err` and go to `SEND_ERR`.
  - `id_ready` takes priority over timeout in the same cycle.
- `SEND_OK`: send 6 bytes in order:
  - `0x5A`
  - ID[31:24], ID[23:16], ID[15:8], ID[7:0]
  - checksum = XOR of the four ID bytes
- `SEND_ERR`: send 2 bytes, `0xA5` then `0xFF`.
- After the last byte is accepted, return to `IDLE`.

**Rules**
- `req` while `busy`=1 is ignored. It is neither queued nor counted.
- The ID is latched once per frame. Changes to `board_identifier` or `id_ready` mid-frame do not alter the frame being sent.
- Byte index is a 3-bit counter. It advances only on handshake (`out_valid` & `out_ready`).
- The wait counter is 16 bits wide. It never wraps, because it is bounded by the timeout.

## Timing

- **Reset values:** `busy`=0, `out_valid`=0, `out_data`=0x00, `timeout_err`=0. State is `IDLE`; all counters are 0.
- **Reset mid-frame:** the frame is aborted. Outputs are at reset values the cycle after `reset` is sampled high, and no partial frame resumes.
- **Request latency:**
  - `req` at cycle N with `id_ready`=1: `busy`=1, `out_valid`=1 and `out_data`=0x5A at cycle N+1.
  - `id_ready` rising at cycle M while in `WAIT_ID`: first byte at cycle M+1.
- **Timeout:** `req` at cycle N with `id_ready` held 0 gives:
  - `timeout_err`=1 at cycle N+`TIMEOUT_CYCLES`;
  - first error byte (`0xA5`) at cycle N+`TIMEOUT_CYCLES`+1.
- **Handshake:**
  - While `out_valid`=1 and `out_ready`=0, `out_data` and `out_valid` hold stable.
  - `out_valid` never drops before acceptance.
  - `out_valid` does not depend combinationally on `out_ready`.
- **Throughput:** with `out_ready` held 1, one byte per cycle. A 6-byte frame occupies cycles N+1..N+6.
- **Frame end:** `busy` falls on the cycle after the last accept. A new `req` is accepted in that same (`IDLE`) cycle.

## Structure

- Shared package `board_id_pkg`:
  - `ID_HDR_OK`=8'h5A
  - `ID_HDR_ERR`=8'hA5
  - `ID_ERR_CODE`=8'hFF
  - `ID_FRAME_LEN`=6
  - `ID_ERR_LEN`=2
  - state encoding (`IDLE`, `WAIT_ID`, `SEND_OK`, `SEND_ERR`)
- Single flat module; no sub-module is warranted.
- The top level wires this block to the board-ID generator instance.

## Test plan

1. **ID already valid:** `id_ready`=1, ID=0x789ABCDE, `out_ready`=1, pulse `req` → bytes 5A 78 9A BC DE 80 on 6 consecutive cycles starting N+1; `busy` low on N+7.
2. **Delayed ID:** `id_ready`=0 at `req`, rises 3800 cycles later (ID 0x789ABCDE) → no `timeout_err`; frame identical to scenario 1, starting one cycle after `id_ready` rises.
3. **Timeout:** `TIMEOUT_CYCLES`=100, `id_ready` held 0 → `timeout_err` pulse at N+100; bytes A5 FF at N+101/N+102.
4. **Backpressure:** `out_ready` toggled 1,0,0,1,… during scenario 1 → byte order and values unchanged; `out_data` stable during every stall.
5. **Request while busy, and ID change mid-frame:** second `req` mid-frame, and ID changed to 0x11223344 mid-frame → exactly one frame emitted, carrying 0x789ABCDE.
6. **Reset after third byte:** assert `reset` after the third byte is accepted → outputs at reset values next cycle; a new `req` yields a complete fresh 6-byte frame.
